// File: rtl/rx_packet_decoder.sv
// rx_packet_decoder: packet layer after the 4-lane aligner.
// Parses the 32-bit header, turns short packets into frame/line strobes
// and streams long-packet payload with byte enables. CRC/trailer bytes
// are dropped. Packets on virtual channels outside VC_ACCEPT are consumed
// silently. Optional header ECC check: define RX_ECC_CHECK_EN.
//
// state     | meaning
// S_IDLE    | waiting for the header word of the next packet
// S_PAYLOAD | long packet, streaming payload words until count exhausted
// S_DRAIN   | discarding CRC/trailer until lane_valid_i drops
module rx_packet_decoder #(
  parameter logic [3:0] VC_ACCEPT = 4'b1111
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        lane_valid_i,
  input  logic [31:0] lane_byte_i,
  output logic        header_valid_o,
  output logic [1:0]  vc_o,
  output logic [5:0]  dt_o,
  output logic [15:0] wc_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        line_start_o,
  output logic        line_end_o,
  output logic [31:0] payload_o,
  output logic        payload_valid_o,
  output logic [3:0]  payload_be_o,
  output logic        payload_last_o,
  output logic        truncated_o,
  output logic        header_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic        pass_q, pass_d;

  logic        hv_d, fs_d, fe_d, ls_d, le_d, pv_d, last_d, trunc_d, err_d;
  logic [1:0]  vc_d;
  logic [5:0]  dt_d;
  logic [15:0] wc_d;
  logic [31:0] payload_d;
  logic [3:0]  be_d;

  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        ecc_ok;
  logic        unused_ecc;

  assign hdr_vc = lane_byte_i[7:6];
  assign hdr_dt = lane_byte_i[5:0];
  assign hdr_wc = lane_byte_i[23:8];

`ifdef RX_ECC_CHECK_EN
  function automatic logic [5:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  assign ecc_ok     = (ecc_calc(lane_byte_i[23:0]) == lane_byte_i[29:24]);
  assign unused_ecc = ^lane_byte_i[31:30];
`else
  assign ecc_ok     = 1'b1;
  assign unused_ecc = ^lane_byte_i[31:24];
`endif

  // State register, remaining-byte counter and per-packet VC pass flag
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state decode and next values of every registered output
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    pass_d    = pass_q;
    vc_d      = vc_o;
    dt_d      = dt_o;
    wc_d      = wc_o;
    hv_d      = 1'b0;
    fs_d      = 1'b0;
    fe_d      = 1'b0;
    ls_d      = 1'b0;
    le_d      = 1'b0;
    pv_d      = 1'b0;
    last_d    = 1'b0;
    trunc_d   = 1'b0;
    err_d     = 1'b0;
    payload_d = '0;
    be_d      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (lane_valid_i) begin
          if (!ecc_ok) begin
            err_d   = 1'b1;
            pass_d  = 1'b0;
            state_d = S_DRAIN;
          end else begin
            pass_d = VC_ACCEPT[hdr_vc];
            if (pass_d) begin
              hv_d = 1'b1;
              vc_d = hdr_vc;
              dt_d = hdr_dt;
              wc_d = hdr_wc;
            end
            if (hdr_dt < 6'h10) begin
              fs_d    = pass_d && (hdr_dt == 6'h00);
              fe_d    = pass_d && (hdr_dt == 6'h01);
              ls_d    = pass_d && (hdr_dt == 6'h02);
              le_d    = pass_d && (hdr_dt == 6'h03);
              state_d = S_DRAIN;
            end else if (hdr_wc != 16'd0) begin
              rem_d   = hdr_wc;
              state_d = S_PAYLOAD;
            end else begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (lane_valid_i) begin
          if (pass_q) begin
            pv_d      = 1'b1;
            payload_d = lane_byte_i;
            last_d    = (rem_q <= 16'd4);
            if (rem_q <= 16'd4) begin
              unique case (rem_q[2:0])
                3'd1:    be_d = 4'h1;
                3'd2:    be_d = 4'h3;
                3'd3:    be_d = 4'h7;
                default: be_d = 4'hF;
              endcase
            end else begin
              be_d = 4'hF;
            end
          end
          if (rem_q <= 16'd4) begin
            rem_d   = '0;
            state_d = S_DRAIN;
          end else begin
            rem_d = rem_q - 16'd4;
          end
        end else begin
          trunc_d = pass_q;
          rem_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!lane_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers: one cycle after the header/payload input cycle
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      header_valid_o  <= 1'b0;
      vc_o            <= '0;
      dt_o            <= '0;
      wc_o            <= '0;
      frame_start_o   <= 1'b0;
      frame_end_o     <= 1'b0;
      line_start_o    <= 1'b0;
      line_end_o      <= 1'b0;
      payload_o       <= '0;
      payload_valid_o <= 1'b0;
      payload_be_o    <= '0;
      payload_last_o  <= 1'b0;
      truncated_o     <= 1'b0;
      header_err_o    <= 1'b0;
    end else begin
      header_valid_o  <= hv_d;
      vc_o            <= vc_d;
      dt_o            <= dt_d;
      wc_o            <= wc_d;
      frame_start_o   <= fs_d;
      frame_end_o     <= fe_d;
      line_start_o    <= ls_d;
      line_end_o      <= le_d;
      payload_o       <= payload_d;
      payload_valid_o <= pv_d;
      payload_be_o    <= be_d;
      payload_last_o  <= last_d;
      truncated_o     <= trunc_d;
      header_err_o    <= err_d;
    end
  end

endmodule

// File: tb/tb_rx_packet_decoder.sv
// Directed bench for rx_packet_decoder (VC_ACCEPT = 4'b0001).
module tb_rx_packet_decoder;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        lane_valid_i;
  logic [31:0] lane_byte_i;
  logic        header_valid_o;
  logic [1:0]  vc_o;
  logic [5:0]  dt_o;
  logic [15:0] wc_o;
  logic        frame_start_o, frame_end_o, line_start_o, line_end_o;
  logic [31:0] payload_o;
  logic        payload_valid_o;
  logic [3:0]  payload_be_o;
  logic        payload_last_o;
  logic        truncated_o;
  logic        header_err_o;

  int errors = 0;
  int checks = 0;

  // pulse vector: {hv, fs, fe, ls, le, pv, last, trunc, err}
  localparam logic [8:0] P_NONE = 9'h000;
  localparam logic [8:0] P_HV   = 9'h100;
  localparam logic [8:0] P_FS   = 9'h080;
  localparam logic [8:0] P_FE   = 9'h040;
  localparam logic [8:0] P_LS   = 9'h020;
  localparam logic [8:0] P_LE   = 9'h010;
  localparam logic [8:0] P_PV   = 9'h008;
  localparam logic [8:0] P_LAST = 9'h004;
  localparam logic [8:0] P_TR   = 9'h002;
  localparam logic [8:0] P_ER   = 9'h001;

  rx_packet_decoder #(.VC_ACCEPT(4'b0001)) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .lane_valid_i    (lane_valid_i),
    .lane_byte_i     (lane_byte_i),
    .header_valid_o  (header_valid_o),
    .vc_o            (vc_o),
    .dt_o            (dt_o),
    .wc_o            (wc_o),
    .frame_start_o   (frame_start_o),
    .frame_end_o     (frame_end_o),
    .line_start_o    (line_start_o),
    .line_end_o      (line_end_o),
    .payload_o       (payload_o),
    .payload_valid_o (payload_valid_o),
    .payload_be_o    (payload_be_o),
    .payload_last_o  (payload_last_o),
    .truncated_o     (truncated_o),
    .header_err_o    (header_err_o)
  );

  always #5 clk_i = ~clk_i;

  // header ECC from parity masks over the 24 header bits
  function automatic logic [5:0] ecc_model(input logic [23:0] d);
    logic [23:0] m [6];
    logic [5:0]  p;
    m[0] = 24'hF12CB7; m[1] = 24'hF2555B; m[2] = 24'h749A6D;
    m[3] = 24'hB8E38E; m[4] = 24'hDF03F0; m[5] = 24'hEFFC00;
    for (int i = 0; i < 6; i++) p[i] = ^(d & m[i]);
    return p;
  endfunction

  function automatic logic [31:0] hdr(input logic [1:0] vc, input logic [5:0] dt,
                                      input logic [15:0] wc);
    logic [23:0] d;
    d = {wc, vc, dt};
    return {2'b00, ecc_model(d), d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] pulses();
    return {header_valid_o, frame_start_o, frame_end_o, line_start_o, line_end_o,
            payload_valid_o, payload_last_o, truncated_o, header_err_o};
  endfunction

  // drive one input cycle at a negedge, check the registered result at the next negedge
  task automatic cyc(input logic v, input logic [31:0] d, input string tag,
                     input logic [8:0] ep, input logic [31:0] epay, input logic [3:0] ebe);
    lane_valid_i = v;
    lane_byte_i  = d;
    @(negedge clk_i);
    chk({tag, ".pulses"}, {23'd0, pulses()}, {23'd0, ep});
    chk({tag, ".payload"}, payload_o, epay);
    chk({tag, ".be"}, {28'd0, payload_be_o}, {28'd0, ebe});
  endtask

  task automatic chk_hdr(input string tag, input logic [1:0] vc, input logic [5:0] dt,
                         input logic [15:0] wc);
    chk({tag, ".vc"}, {30'd0, vc_o}, {30'd0, vc});
    chk({tag, ".dt"}, {26'd0, dt_o}, {26'd0, dt});
    chk({tag, ".wc"}, {16'd0, wc_o}, {16'd0, wc});
  endtask

  initial begin
    reset_n_i    = 1'b0;
    lane_valid_i = 1'b0;
    lane_byte_i  = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("reset.pulses", {23'd0, pulses()}, 32'd0);
    chk("reset.payload", payload_o, 32'd0);
    chk_hdr("reset", 2'd0, 6'd0, 16'd0);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    // frame start short packet, all-zero header word
    cyc(1'b1, 32'h0000_0000, "fs.hdr", P_HV | P_FS, 32'd0, 4'h0);
    chk_hdr("fs", 2'd0, 6'h00, 16'd0);
    cyc(1'b0, 32'd0, "fs.idle", P_NONE, 32'd0, 4'h0);

    // long packet WC=10: F, F, 3+last, CRC dropped
    cyc(1'b1, hdr(2'd0, 6'h2B, 16'd10), "lp.hdr", P_HV, 32'd0, 4'h0);
    chk_hdr("lp", 2'd0, 6'h2B, 16'd10);
    cyc(1'b1, 32'h4433_2211, "lp.w0", P_PV, 32'h4433_2211, 4'hF);
    cyc(1'b1, 32'h8877_6655, "lp.w1", P_PV, 32'h8877_6655, 4'hF);
    cyc(1'b1, 32'hCCBB_AA99, "lp.w2", P_PV | P_LAST, 32'hCCBB_AA99, 4'h3);
    cyc(1'b1, 32'hDEAD_BEEF, "lp.crc", P_NONE, 32'd0, 4'h0);
    cyc(1'b0, 32'd0, "lp.idle", P_NONE, 32'd0, 4'h0);
    chk_hdr("lp.hold", 2'd0, 6'h2B, 16'd10);

    // WC=5: F then 1+last; WC=3: 7+last in one word
    cyc(1'b1, hdr(2'd0, 6'h2A, 16'd5), "w5.hdr", P_HV, 32'd0, 4'h0);
    cyc(1'b1, 32'h0403_0201, "w5.w0", P_PV, 32'h0403_0201, 4'hF);
    cyc(1'b1, 32'h0807_0605, "w5.w1", P_PV | P_LAST, 32'h0807_0605, 4'h1);
    cyc(1'b0, 32'd0, "w5.idle", P_NONE, 32'd0, 4'h0);
    cyc(1'b1, hdr(2'd0, 6'h2A, 16'd3), "w3.hdr", P_HV, 32'd0, 4'h0);
    cyc(1'b1, 32'h1234_5678, "w3.w0", P_PV | P_LAST, 32'h1234_5678, 4'h7);
    cyc(1'b0, 32'd0, "w3.idle", P_NONE, 32'd0, 4'h0);

    // long packet with WC=0: header only, then drain
    cyc(1'b1, hdr(2'd0, 6'h2B, 16'd0), "w0.hdr", P_HV, 32'd0, 4'h0);
    cyc(1'b1, 32'hFFFF_FFFF, "w0.drain", P_NONE, 32'd0, 4'h0);
    cyc(1'b0, 32'd0, "w0.idle", P_NONE, 32'd0, 4'h0);

    // truncation: WC=16, valid drops after 2 words
    cyc(1'b1, hdr(2'd0, 6'h2B, 16'd16), "tr.hdr", P_HV, 32'd0, 4'h0);
    cyc(1'b1, 32'hA1A2_A3A4, "tr.w0", P_PV, 32'hA1A2_A3A4, 4'hF);
    cyc(1'b1, 32'hB1B2_B3B4, "tr.w1", P_PV, 32'hB1B2_B3B4, 4'hF);
    cyc(1'b0, 32'd0, "tr.cut", P_TR, 32'd0, 4'h0);
    cyc(1'b1, hdr(2'd0, 6'h03, 16'h1234), "tr.next", P_HV | P_LE, 32'd0, 4'h0);
    chk_hdr("tr.next", 2'd0, 6'h03, 16'h1234);
    cyc(1'b0, 32'd0, "tr.idle", P_NONE, 32'd0, 4'h0);

    // VC filter: VC 1 long packet silent, then VC 0 frame end
    cyc(1'b1, hdr(2'd1, 6'h2B, 16'd8), "vf.hdr", P_NONE, 32'd0, 4'h0);
    cyc(1'b1, 32'h1111_1111, "vf.w0", P_NONE, 32'd0, 4'h0);
    cyc(1'b1, 32'h2222_2222, "vf.w1", P_NONE, 32'd0, 4'h0);
    cyc(1'b1, 32'h3333_3333, "vf.crc", P_NONE, 32'd0, 4'h0);
    cyc(1'b0, 32'd0, "vf.idle", P_NONE, 32'd0, 4'h0);
    chk_hdr("vf.hold", 2'd0, 6'h03, 16'h1234);
    cyc(1'b1, hdr(2'd0, 6'h01, 16'd0), "vf.fe", P_HV | P_FE, 32'd0, 4'h0);
    cyc(1'b0, 32'd0, "vf.fe.idle", P_NONE, 32'd0, 4'h0);

    // VC filter on a truncated packet: no truncated_o either
    cyc(1'b1, hdr(2'd2, 6'h2B, 16'd16), "vt.hdr", P_NONE, 32'd0, 4'h0);
    cyc(1'b0, 32'd0, "vt.cut", P_NONE, 32'd0, 4'h0);

`ifdef RX_ECC_CHECK_EN
    cyc(1'b1, hdr(2'd0, 6'h02, 16'h0055) ^ 32'h0100_0000, "ecc.bad", P_ER, 32'd0, 4'h0);
    chk_hdr("ecc.bad", 2'd0, 6'h01, 16'd0);
    cyc(1'b1, 32'h5555_5555, "ecc.drain", P_NONE, 32'd0, 4'h0);
    cyc(1'b0, 32'd0, "ecc.idle", P_NONE, 32'd0, 4'h0);
    cyc(1'b1, hdr(2'd0, 6'h02, 16'h0055), "ecc.good", P_HV | P_LS, 32'd0, 4'h0);
    chk_hdr("ecc.good", 2'd0, 6'h02, 16'h0055);
    cyc(1'b0, 32'd0, "ecc.good.idle", P_NONE, 32'd0, 4'h0);
`endif

    // reset mid-payload clears outputs asynchronously
    cyc(1'b1, hdr(2'd0, 6'h2B, 16'd12), "rs.hdr", P_HV, 32'd0, 4'h0);
    cyc(1'b1, 32'hCAFE_F00D, "rs.w0", P_PV, 32'hCAFE_F00D, 4'hF);
    lane_byte_i = 32'h0BAD_0BAD;
    #2 reset_n_i = 1'b0;
    #1;
    chk("rs.async.pulses", {23'd0, pulses()}, 32'd0);
    chk("rs.async.payload", payload_o, 32'd0);
    chk("rs.async.be", {28'd0, payload_be_o}, 32'd0);
    lane_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    chk_hdr("rs.clear", 2'd0, 6'd0, 16'd0);
    cyc(1'b1, hdr(2'd0, 6'h02, 16'd0), "rs.ls", P_HV | P_LS, 32'd0, 4'h0);
    chk_hdr("rs.ls", 2'd0, 6'h02, 16'd0);
    cyc(1'b0, 32'd0, "rs.idle", P_NONE, 32'd0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_packet_decoder.md
# rx_packet_decoder

Packet-layer stage directly downstream of the 4-lane aligner in the CSI-2 receive path. Consumes the lane-aligned 32-bit word stream (sync bytes already stripped, all lanes deskewed), parses the 32-bit packet header, decodes short packets into frame/line strobes and streams long-packet payload with per-byte enables. Trailing CRC and trailer bytes are discarded; virtual channels outside a configurable mask are silently consumed.

## Interface
- VC_ACCEPT, 4'b1111, bit n set = virtual channel n is passed; packets on cleared VCs are consumed with no outputs
- clk_i  in  1  byte clock; all logic on rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- lane_valid_i  in  1  aligned-stream valid; high for the full burst of one packet, low between packets
- lane_byte_i  in  32  aligned bytes; lane0 in [7:0] … lane3 in [31:24]
- header_valid_o  out  1  one-cycle pulse: accepted header, vc_o/dt_o/wc_o updated
- vc_o  out  2  virtual channel of last accepted header
- dt_o  out  6  data type of last accepted header
- wc_o  out  16  word count (long) or short-packet data field
- frame_start_o / frame_end_o / line_start_o / line_end_o  out  1 each  one-cycle pulses for DT 0x00/0x01/0x02/0x03
- payload_o  out  32  payload word, byte order as input
- payload_valid_o  out  1  payload_o qualified
- payload_be_o  out  4  byte enables for payload_o
- payload_last_o  out  1  marks final payload word of a packet
- truncated_o  out  1  one-cycle pulse: lane_valid_i fell before word count exhausted
- header_err_o  out  1  one-cycle pulse: ECC mismatch (only with RX_ECC_CHECK_EN)

## Operation
- Header word = first cycle with lane_valid_i high in IDLE: DI = [7:0] (VC=[7:6], DT=[5:0]), WC = {[23:16],[15:8]}, ECC = [31:24].
- States: IDLE, PAYLOAD, DRAIN.
- IDLE → header captured. Short packet (DT < 0x10): emit header_valid_o and matching strobe (DT 0x00–0x03 only; 0x04–0x0F header only), go DRAIN. Long packet, WC > 0: load 16-bit remaining counter = WC, go PAYLOAD. Long packet, WC = 0: header only, go DRAIN.
- VC not set in VC_ACCEPT: no header_valid_o/strobes/payload, but state sequence identical.
- PAYLOAD: each lane_valid_i-high cycle outputs one word; remaining decrements by 4 (saturating at 0). Word with remaining ≤ 4 is last: payload_last_o=1, be = 4'hF/4'h1/4'h3/4'h7 for remaining 4/1/2/3; go DRAIN. Other words be = 4'hF.
- PAYLOAD with lane_valid_i low: truncated_o pulse, no payload_last_o, go IDLE.
- DRAIN: ignore data (CRC, trailer) until lane_valid_i low, then IDLE. Low in same cycle as entry → IDLE next cycle.
- Reset (any time, including mid-packet): state IDLE, counter 0, all outputs 0.

## Timing
- All outputs registered; 1-cycle latency from header/payload input cycle to output.
- Pulses high exactly one cycle; payload_valid_o high exactly once per accepted payload word, never outside PAYLOAD.
- vc_o/dt_o/wc_o hold until next accepted header.
- New header accepted only from IDLE; minimum one lane_valid_i-low cycle between packets.
- payload_be_o/payload_o are 0 when payload_valid_o low.

## Configuration
- RX_ECC_CHECK_EN defined: 6-bit CSI-2 header ECC computed over header bits [23:0] and compared with [29:24]; mismatch → header_err_o pulse one cycle after header, no header_valid_o/strobes/payload, go DRAIN.
- Undefined: ECC byte ignored, header_err_o tied 0, every header accepted.

## Test plan
- Frame start: reset, lane_valid_i 1 cycle with 32'h00000000 → header_valid_o and frame_start_o one cycle later, vc_o=0, dt_o=0, wc_o=0; no payload.
- Long packet: header DT=0x2B WC=10 (ECC from bench model), then 4 words → payload_valid_o ×3, be F,F,3 with last on third; fourth (CRC) word dropped.
- Truncation: header WC=16, lane_valid_i low after 2 payload words → 2 payload words, truncated_o pulse, no payload_last_o; next packet decodes normally.
- VC filter: VC_ACCEPT=4'b0001, long packet on VC 1 → no outputs at all; following VC 0 frame_end (DI=0x01) → frame_end_o.
- ECC (RX_ECC_CHECK_EN): header with one ECC bit flipped → header_err_o, no header_valid_o; same header correct → header_valid_o.
- Reset mid-payload: reset_n_i low during PAYLOAD → all outputs 0 immediately; after release, header DI=0x02 → line_start_o.
